// File: rtl/obg_frame_if.sv
// Frame controller bundle: MAC request plus signal/payload generator links.
// master = requester/generator side, slave = frame controller.
interface obg_frame_if #(
  parameter int LEN_W = 16
);
  logic             req_vld;
  logic             req_rdy;
  logic [LEN_W-1:0] req_len;
  logic [3:0]       req_type;
  logic [LEN_W-1:0] ssg_di_len;
  logic [3:0]       ssg_di_type;
  logic             ssg_di_vld;
  logic             ssg_do_vld;
  logic             pld_new_frame;
  logic             pld_do_vld;
  logic             frame_busy;
  logic             frame_done;
  logic             err_timeout;

  modport master (
    output req_vld, req_len, req_type,
    output ssg_do_vld, pld_do_vld,
    input  req_rdy, ssg_di_len, ssg_di_type,
    input  ssg_di_vld, pld_new_frame,
    input  frame_busy, frame_done, err_timeout
  );

  modport slave (
    input  req_vld, req_len, req_type,
    input  ssg_do_vld, pld_do_vld,
    output req_rdy, ssg_di_len, ssg_di_type,
    output ssg_di_vld, pld_new_frame,
    output frame_busy, frame_done, err_timeout
  );
endinterface

// File: rtl/obg_frame_ctrl.sv
// Serial SIGNAL-then-payload frame sequencer for the original-bits generator.
// Define OBG_CTRL_TIMEOUT_EN to build the per-beat watchdog.
module obg_frame_ctrl #(
  parameter int SIG_BITS    = 24,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic      clk,
  input logic      rst,
  obg_frame_if.slave bus
);

  localparam int SC_W = (SIG_BITS > 1) ? $clog2(SIG_BITS) : 1;
  localparam logic [SC_W-1:0] SIG_LAST = SC_W'(SIG_BITS - 1);
  localparam int PC_W = LEN_W + 3;

  if (TIMEOUT_CYC == 0) begin : g_to_chk
    $error("TIMEOUT_CYC must be nonzero");
  end

  typedef enum logic [2:0] {
    IDLE,
    SIG_CFG,
    SIG_RUN,
    PLD_START,
    PLD_RUN,
    DONE
  } state_t;

  state_t           state;
  logic             req_rdy_q;
  logic [LEN_W-1:0] len_q;
  logic [3:0]       type_q;
  logic             ssg_vld_q;
  logic             pld_nf_q;
  logic             busy_q;
  logic             done_q;
  logic [SC_W-1:0]  sig_cnt;
  logic [PC_W-1:0]  pld_cnt;
  logic [PC_W-1:0]  pld_last;

`ifdef OBG_CTRL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic            to_q;
  logic [WD_W-1:0] wd_cnt;
  logic            in_run;
  logic            beat;

  assign in_run = (state == SIG_RUN) || (state == PLD_RUN);
  assign beat   = ((state == SIG_RUN) && bus.ssg_do_vld)
               || ((state == PLD_RUN) && bus.pld_do_vld);
  assign bus.err_timeout = to_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_rdy_q <= 1'b1;
      len_q     <= '0;
      type_q    <= '0;
      ssg_vld_q <= 1'b0;
      pld_nf_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sig_cnt   <= '0;
      pld_cnt   <= '0;
      pld_last  <= '0;
`ifdef OBG_CTRL_TIMEOUT_EN
      to_q      <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      ssg_vld_q <= 1'b0;
      pld_nf_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef OBG_CTRL_TIMEOUT_EN
      to_q      <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (bus.req_vld && req_rdy_q) begin
            len_q     <= bus.req_len;
            type_q    <= bus.req_type;
            // last payload beat index; wide enough for len = 2^LEN_W-1
            pld_last  <= {bus.req_len, 3'b000} - 1'b1;
            sig_cnt   <= '0;
            pld_cnt   <= '0;
            ssg_vld_q <= 1'b1;
            req_rdy_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= SIG_CFG;
          end
        end
        SIG_CFG: state <= SIG_RUN;
        SIG_RUN: begin
          if (bus.ssg_do_vld) begin
            if (sig_cnt == SIG_LAST) begin
              if (len_q == '0) begin
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                pld_nf_q <= 1'b1;
                state    <= PLD_START;
              end
            end else begin
              sig_cnt <= sig_cnt + 1'b1;
            end
          end
        end
        PLD_START: state <= PLD_RUN;
        PLD_RUN: begin
          if (bus.pld_do_vld) begin
            if (pld_cnt == pld_last) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              pld_cnt <= pld_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          req_rdy_q <= 1'b1;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          req_rdy_q <= 1'b1;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
`ifdef OBG_CTRL_TIMEOUT_EN
      // overrides the case above: a stalled generator abandons the frame
      if (in_run && !beat) begin
        if (wd_cnt == WD_LAST) begin
          to_q      <= 1'b1;
          req_rdy_q <= 1'b1;
          busy_q    <= 1'b0;
          wd_cnt    <= '0;
          state     <= IDLE;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
`endif
    end
  end

  assign bus.req_rdy       = req_rdy_q;
  assign bus.ssg_di_len    = len_q;
  assign bus.ssg_di_type   = type_q;
  assign bus.ssg_di_vld    = ssg_vld_q;
  assign bus.pld_new_frame = pld_nf_q;
  assign bus.frame_busy    = busy_q;
  assign bus.frame_done    = done_q;

endmodule
